conv_encoder: RTL

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/conv_encoder.sv | 114 +++++++++++
 1 files changed

// File: rtl/conv_encoder.sv
// K=7 rate-1/2 convolutional encoder (g0=133o, g1=171o) with 2/3 and 3/4 puncturing.
// Coded bits leave serially, one per cycle; a one-bit hold buffer back-pressures the input.
module conv_encoder (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Init,
   input  logic [1:0] Rate,
   input  logic       Data,
   input  logic       En,
   output logic       Ready,
   output logic       Out,
   output logic       Out_valid
);

   localparam int unsigned SR_W = 6;
   localparam int unsigned PH_W = 2;

   typedef enum logic [1:0] {
      RATE_1_2 = 2'd0,
      RATE_2_3 = 2'd1,
      RATE_3_4 = 2'd2
   } rate_e;

   logic [SR_W-1:0] sr;          // sr[k-1] holds the bit accepted k accepts earlier
   logic [PH_W-1:0] phase;
   rate_e           rate;
   logic            hold;
   logic            hold_valid;

   logic            accept;
   logic            code_a;
   logic            code_b;
   logic            keep_a;
   logic            keep_b;
   logic [PH_W-1:0] phase_nxt;
   rate_e           rate_sel;

   assign Ready  = ~hold_valid & ~Init;
   assign accept = En & Ready;

   // Both generator outputs for the bit currently offered on Data
   always_comb begin
      code_a = Data ^ sr[1] ^ sr[2] ^ sr[4] ^ sr[5];
      code_b = Data ^ sr[0] ^ sr[1] ^ sr[2] ^ sr[5];
   end

   // Unused code 11 falls back to rate 1/2
   always_comb begin
      rate_sel = RATE_1_2;
      if (Rate != 2'b11) rate_sel = rate_e'(Rate);
   end

   // Puncture pattern and phase wrap for the latched rate
   always_comb begin
      keep_a    = 1'b1;
      keep_b    = 1'b1;
      phase_nxt = '0;
      case (rate)
         RATE_2_3: begin
            keep_b    = (phase == PH_W'(0));
            phase_nxt = (phase == PH_W'(0)) ? PH_W'(1) : PH_W'(0);
         end
         RATE_3_4: begin
            keep_a    = (phase != PH_W'(2));
            keep_b    = (phase != PH_W'(1));
            phase_nxt = (phase == PH_W'(2)) ? PH_W'(0) : PH_W'(phase + PH_W'(1));
         end
         default: begin
            keep_a    = 1'b1;
            keep_b    = 1'b1;
            phase_nxt = '0;
         end
      endcase
   end

   // Init outranks accept; an accepted pair emits A now and parks B for the next cycle
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sr         <= '0;
         phase      <= '0;
         rate       <= RATE_1_2;
         hold       <= 1'b0;
         hold_valid <= 1'b0;
         Out        <= 1'b0;
         Out_valid  <= 1'b0;
      end else if (Init) begin
         sr         <= '0;
         phase      <= '0;
         rate       <= rate_sel;
         hold       <= 1'b0;
         hold_valid <= 1'b0;
         Out_valid  <= 1'b0;
      end else if (accept) begin
         sr        <= {sr[SR_W-2:0], Data};
         phase     <= phase_nxt;
         Out_valid <= 1'b1;
         if (keep_a) begin
            Out        <= code_a;
            hold       <= code_b;
            hold_valid <= keep_b;
         end else begin
            Out        <= code_b;
            hold_valid <= 1'b0;
         end
      end else if (hold_valid) begin
         Out        <= hold;
         Out_valid  <= 1'b1;
         hold_valid <= 1'b0;
      end else begin
         Out_valid <= 1'b0;
      end
   end

endmodule
